// File: rtl/coproc_commit_tracker_if.sv
// Purpose : bundles the alloc/done/commit/result/status signals of the
//           coprocessor commit tracker into one interface.
// Ports   : none (pure signal bundle).
//   master modport : core/datapath side (drives alloc/done/commit, result_ready).
//   slave modport  : tracker side (drives alloc_ready, result_*, count, protocol_err).
interface coproc_commit_tracker_if #(
    parameter int unsigned X_ID_WIDTH  = 4,
    parameter int unsigned X_RFW_WIDTH = 32,
    parameter int unsigned DEPTH       = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                   alloc_valid;
    logic                   alloc_ready;
    logic [X_ID_WIDTH-1:0]  alloc_id;
    logic [4:0]             alloc_rd;
    logic                   alloc_we;

    logic                   done_valid;
    logic [X_ID_WIDTH-1:0]  done_id;
    logic [X_RFW_WIDTH-1:0] done_data;

    logic                   commit_valid;
    logic [X_ID_WIDTH-1:0]  commit_id;
    logic                   commit_kill;

    logic                   result_valid;
    logic                   result_ready;
    logic [X_ID_WIDTH-1:0]  result_id;
    logic [X_RFW_WIDTH-1:0] result_data;
    logic [4:0]             result_rd;
    logic                   result_we;

    logic [CNT_W-1:0]       count;
    logic                   protocol_err;

    modport master (
        output alloc_valid, alloc_id, alloc_rd, alloc_we,
        output done_valid, done_id, done_data,
        output commit_valid, commit_id, commit_kill,
        output result_ready,
        input  alloc_ready, result_valid, result_id, result_data, result_rd, result_we,
        input  count, protocol_err
    );

    modport slave (
        input  alloc_valid, alloc_id, alloc_rd, alloc_we,
        input  done_valid, done_id, done_data,
        input  commit_valid, commit_id, commit_kill,
        input  result_ready,
        output alloc_ready, result_valid, result_id, result_data, result_rd, result_we,
        output count, protocol_err
    );
endinterface

// File: rtl/coproc_commit_tracker.sv
// Purpose : in-order tracker for coprocessor instructions. Records accepted
//           instructions, collects datapath completion data, matches
//           commit/kill by ID and emits one result per committed instruction
//           in allocation order through a registered valid/ready stage.
// Ports   :
//   clk_i  - clock
//   rst_i  - synchronous active-high reset
//   bus    - slave modport: alloc_*, done_*, commit_*, result_*, count,
//            protocol_err (alloc_ready is combinational, the rest registered)
module coproc_commit_tracker #(
    parameter int unsigned X_ID_WIDTH  = 4,
    parameter int unsigned X_RFW_WIDTH = 32,
    parameter int unsigned DEPTH       = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    coproc_commit_tracker_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0]  id;
        logic [4:0]             rd;
        logic                   we;
        logic [X_RFW_WIDTH-1:0] data;
        logic                   live;
        logic                   done;
        logic                   committed;
        logic                   killed;
    } entry_t;

    entry_t                 r_mem [DEPTH];
    logic [PTR_W-1:0]       r_head;
    logic [PTR_W-1:0]       r_tail;
    logic [CNT_W-1:0]       r_count;

    logic                   r_res_valid;
    logic [X_ID_WIDTH-1:0]  r_res_id;
    logic [X_RFW_WIDTH-1:0] r_res_data;
    logic [4:0]             r_res_rd;
    logic                   r_res_we;
    logic                   r_perr;

    entry_t                 w_nxt [DEPTH];
    entry_t                 w_head;
    logic                   w_id_busy;
    logic                   w_alloc_ready;
    logic                   w_alloc_fire;
    logic                   w_done_hit;
    logic                   w_commit_hit;
    logic                   w_out_free;
    logic                   w_ret_kill;
    logic                   w_ret_res;
    logic                   w_retire;

    // Allocation is allowed when there is room and the ID is not already live.
    always_comb begin
        w_id_busy = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (r_mem[i].live && (r_mem[i].id == bus.alloc_id)) begin
                w_id_busy = 1'b1;
            end
        end
        w_alloc_ready = (r_count < CNT_W'(DEPTH)) && !w_id_busy;
        w_alloc_fire  = bus.alloc_valid && w_alloc_ready;
    end

    // Next view of every entry: the allocation is applied first so that a
    // done/commit naming the new ID in the same cycle lands on the new entry.
    always_comb begin
        w_done_hit   = 1'b0;
        w_commit_hit = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_nxt[i] = r_mem[i];
            if (w_alloc_fire && (r_tail == PTR_W'(i))) begin
                w_nxt[i].id        = bus.alloc_id;
                w_nxt[i].rd        = bus.alloc_rd;
                w_nxt[i].we        = bus.alloc_we;
                w_nxt[i].data      = '0;
                w_nxt[i].live      = 1'b1;
                w_nxt[i].done      = 1'b0;
                w_nxt[i].committed = 1'b0;
                w_nxt[i].killed    = 1'b0;
            end
            if (bus.done_valid && w_nxt[i].live && (w_nxt[i].id == bus.done_id)) begin
                w_done_hit = 1'b1;
                if (!w_nxt[i].killed) begin
                    w_nxt[i].done = 1'b1;
                    w_nxt[i].data = bus.done_data;
                end
            end
            if (bus.commit_valid && w_nxt[i].live && (w_nxt[i].id == bus.commit_id)) begin
                w_commit_hit = 1'b1;
                // Only the first commit/kill to an entry takes effect.
                if (!w_nxt[i].committed && !w_nxt[i].killed) begin
                    if (bus.commit_kill) begin
                        w_nxt[i].killed = 1'b1;
                    end else begin
                        w_nxt[i].committed = 1'b1;
                    end
                end
            end
        end
    end

    // Head retirement decided on the next view, so the last of commit/done
    // shows up as result_valid one cycle later.
    always_comb begin
        w_head     = w_nxt[r_head];
        w_out_free = !r_res_valid || bus.result_ready;
        w_ret_kill = w_head.live && w_head.killed;
        w_ret_res  = w_head.live && !w_head.killed && w_head.committed &&
                     w_head.done && w_out_free;
        w_retire   = w_ret_kill || w_ret_res;
    end

    // Entry storage, pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= w_nxt[i];
                if (w_retire && (r_head == PTR_W'(i))) begin
                    r_mem[i].live <= 1'b0;
                end
            end
            if (w_alloc_fire) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_retire) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_alloc_fire) - CNT_W'(w_retire);
        end
    end

    // Result output stage and error pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_data  <= '0;
            r_res_rd    <= '0;
            r_res_we    <= 1'b0;
            r_perr      <= 1'b0;
        end else begin
            if (w_ret_res) begin
                r_res_valid <= 1'b1;
                r_res_id    <= w_head.id;
                r_res_data  <= w_head.data;
                r_res_rd    <= w_head.rd;
                r_res_we    <= w_head.we;
            end else if (r_res_valid && bus.result_ready) begin
                r_res_valid <= 1'b0;
            end
            r_perr <= (bus.done_valid && !w_done_hit) ||
                      (bus.commit_valid && !w_commit_hit);
        end
    end

    assign bus.alloc_ready  = w_alloc_ready;
    assign bus.result_valid = r_res_valid;
    assign bus.result_id    = r_res_id;
    assign bus.result_data  = r_res_data;
    assign bus.result_rd    = r_res_rd;
    assign bus.result_we    = r_res_we;
    assign bus.count        = r_count;
    assign bus.protocol_err = r_perr;
endmodule

// File: tb/tb_coproc_commit_tracker.sv
// Purpose : self-checking bench for coproc_commit_tracker. Expected results
//           are queued when commits are driven and compared when the DUT
//           hands a result over; held results are checked for stability.
module tb_coproc_commit_tracker;
    logic clk;
    logic rst;

    typedef struct packed {
        logic [3:0]  id;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
    } res_t;

    res_t sb_q[$];
    res_t live_q[$];
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   n_results = 0;

    coproc_commit_tracker_if #(.X_ID_WIDTH(4), .X_RFW_WIDTH(32), .DEPTH(4)) bus ();

    coproc_commit_tracker #(.X_ID_WIDTH(4), .X_RFW_WIDTH(32), .DEPTH(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Result monitor: sampled on the falling edge, between driver updates.
    logic held = 1'b0;
    res_t held_v;
    always @(negedge clk) begin
        res_t cur;
        res_t e;
        cur = {bus.result_id, bus.result_rd, bus.result_we, bus.result_data};
        if (!rst && bus.result_valid) begin
            if (held) chk("hold_stable", 64'(cur), 64'(held_v));
            if (bus.result_ready) begin
                chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("res_id",   64'(cur.id),   64'(e.id));
                    chk("res_rd",   64'(cur.rd),   64'(e.rd));
                    chk("res_we",   64'(cur.we),   64'(e.we));
                    chk("res_data", 64'(cur.data), 64'(e.data));
                end
                n_results++;
                held = 1'b0;
            end else begin
                held   = 1'b1;
                held_v = cur;
            end
        end else begin
            held = 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.alloc_valid  = 1'b0;
        bus.done_valid   = 1'b0;
        bus.commit_valid = 1'b0;
    endtask

    task automatic set_alloc(input logic [3:0] id, input logic [4:0] rd, input logic we);
        bus.alloc_valid = 1'b1;
        bus.alloc_id    = id;
        bus.alloc_rd    = rd;
        bus.alloc_we    = we;
    endtask

    task automatic set_done(input logic [3:0] id, input logic [31:0] data);
        bus.done_valid = 1'b1;
        bus.done_id    = id;
        bus.done_data  = data;
    endtask

    task automatic set_commit(input logic [3:0] id, input logic kill);
        bus.commit_valid = 1'b1;
        bus.commit_id    = id;
        bus.commit_kill  = kill;
    endtask

    task automatic push(input logic [3:0] id, input logic [4:0] rd, input logic we,
                        input logic [31:0] data);
        sb_q.push_back({id, rd, we, data});
    endtask

    initial begin
        res_t       m;
        logic [3:0] nid;
        logic [31:0] d;

        rst = 1'b1;
        bus.alloc_valid = 1'b0; bus.alloc_id = '0; bus.alloc_rd = '0; bus.alloc_we = 1'b0;
        bus.done_valid = 1'b0;  bus.done_id = '0;  bus.done_data = '0;
        bus.commit_valid = 1'b0; bus.commit_id = '0; bus.commit_kill = 1'b0;
        bus.result_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_valid", 64'(bus.result_valid), 64'd0);
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_perr",  64'(bus.protocol_err), 64'd0);
        chk("rst_id",    64'(bus.result_id), 64'd0);
        chk("rst_data",  64'(bus.result_data), 64'd0);
        chk("rst_ready", 64'(bus.alloc_ready), 64'd1);

        // Single flow
        bus.result_ready = 1'b1;
        set_alloc(4'd3, 5'd5, 1'b1); tick();
        chk("t1_count1", 64'(bus.count), 64'd1);
        set_done(4'd3, 32'hDEADBEEF); tick();
        chk("t1_perr", 64'(bus.protocol_err), 64'd0);
        chk("t1_not_yet", 64'(bus.result_valid), 64'd0);
        set_commit(4'd3, 1'b0); push(4'd3, 5'd5, 1'b1, 32'hDEADBEEF); tick();
        chk("t1_valid", 64'(bus.result_valid), 64'd1);
        chk("t1_count0", 64'(bus.count), 64'd0);
        tick();
        chk("t1_drop", 64'(bus.result_valid), 64'd0);

        // Order and backpressure
        bus.result_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            set_alloc(4'(i), 5'(10 + i), 1'b1); tick();
            push(4'(i), 5'(10 + i), 1'b1, 32'h1000 + 32'(i));
        end
        chk("t2_count3", 64'(bus.count), 64'd3);
        for (int i = 3; i >= 1; i--) begin
            set_done(4'(i), 32'h1000 + 32'(i)); set_commit(4'(i), 1'b0); tick();
        end
        chk("t2_valid", 64'(bus.result_valid), 64'd1);
        chk("t2_first_id", 64'(bus.result_id), 64'd1);
        repeat (4) tick();
        chk("t2_still_held", 64'(bus.result_valid), 64'd1);
        bus.result_ready = 1'b1;
        repeat (4) tick();
        chk("t2_drained", 64'(bus.count), 64'd0);
        chk("t2_valid_low", 64'(bus.result_valid), 64'd0);

        // Kill, with an older entry blocking so the killed one stays live
        set_alloc(4'd2, 5'd2, 1'b0); tick();
        set_alloc(4'd4, 5'd4, 1'b1); tick();
        set_alloc(4'd5, 5'd5, 1'b1); tick();
        set_commit(4'd4, 1'b1); tick();
        chk("t3_kill_perr", 64'(bus.protocol_err), 64'd0);
        chk("t3_count", 64'(bus.count), 64'd3);
        set_done(4'd4, 32'h4444); tick();
        chk("t3_done_killed_no_err", 64'(bus.protocol_err), 64'd0);
        set_done(4'd2, 32'h2222); set_commit(4'd2, 1'b0); push(4'd2, 5'd2, 1'b0, 32'h2222); tick();
        set_done(4'd5, 32'h5555); set_commit(4'd5, 1'b0); push(4'd5, 5'd5, 1'b1, 32'h5555); tick();
        repeat (3) tick();
        chk("t3_count0", 64'(bus.count), 64'd0);
        set_done(4'd4, 32'h4444); tick();
        chk("t3_stale_done_err", 64'(bus.protocol_err), 64'd1);
        tick();
        chk("t3_err_pulse", 64'(bus.protocol_err), 64'd0);

        // Full and three pointer wraps
        for (int i = 8; i <= 11; i++) begin
            set_alloc(4'(i), 5'(i), i[0]); tick();
            live_q.push_back({4'(i), 5'(i), i[0], 32'h0});
        end
        chk("t4_full_count", 64'(bus.count), 64'd4);
        set_alloc(4'd12, 5'd12, 1'b0); #1;
        chk("t4_full_ready", 64'(bus.alloc_ready), 64'd0);
        tick();
        chk("t4_drop_count", 64'(bus.count), 64'd4);
        chk("t4_drop_perr", 64'(bus.protocol_err), 64'd0);
        for (int k = 0; k < 12; k++) begin
            nid = 4'(12 + k);
            m = live_q.pop_front();
            d = 32'hA5A50000 | 32'(k);
            m.data = d;
            sb_q.push_back(m);
            bus.alloc_id = nid;
            set_done(m.id, d); set_commit(m.id, 1'b0); #1;
            chk("t4_full_retire_ready", 64'(bus.alloc_ready), 64'd0);
            tick();
            chk("t4_count3", 64'(bus.count), 64'd3);
            bus.alloc_id = live_q[0].id; #1;
            chk("t4_dup_ready", 64'(bus.alloc_ready), 64'd0);
            bus.alloc_id = nid; #1;
            chk("t4_new_ready", 64'(bus.alloc_ready), 64'd1);
            set_alloc(nid, 5'(nid), nid[0]); tick();
            live_q.push_back({nid, 5'(nid), nid[0], 32'h0});
            chk("t4_count4", 64'(bus.count), 64'd4);
        end
        for (int k = 0; k < 4; k++) begin
            m = live_q.pop_front();
            m.data = 32'hBEEF0000 | 32'(k);
            sb_q.push_back(m);
            set_done(m.id, m.data); set_commit(m.id, 1'b0); tick();
        end
        repeat (2) tick();
        chk("t4_drain_count", 64'(bus.count), 64'd0);

        // Same-cycle alloc + done + commit
        set_alloc(4'd7, 5'd3, 1'b1); set_done(4'd7, 32'h77777777); set_commit(4'd7, 1'b0);
        push(4'd7, 5'd3, 1'b1, 32'h77777777); tick();
        chk("t5_valid", 64'(bus.result_valid), 64'd1);
        chk("t5_id", 64'(bus.result_id), 64'd7);
        chk("t5_data", 64'(bus.result_data), 64'h77777777);
        chk("t5_count", 64'(bus.count), 64'd0);
        set_alloc(4'd6, 5'd9, 1'b0); set_done(4'd6, 32'h66); set_commit(4'd6, 1'b0);
        push(4'd6, 5'd9, 1'b0, 32'h66); tick();
        chk("t5_we0_valid", 64'(bus.result_valid), 64'd1);
        chk("t5_we0", 64'(bus.result_we), 64'd0);
        tick();

        // Protocol error
        set_commit(4'd9, 1'b0); tick();
        chk("t6_commit_err", 64'(bus.protocol_err), 64'd1);
        tick();
        chk("t6_err_clear", 64'(bus.protocol_err), 64'd0);

        // Reset while a result is held under backpressure
        bus.result_ready = 1'b0;
        set_alloc(4'd1, 5'd1, 1'b1); tick();
        set_alloc(4'd2, 5'd2, 1'b1); set_done(4'd1, 32'h11); set_commit(4'd1, 1'b0); tick();
        chk("t6_pre_valid", 64'(bus.result_valid), 64'd1);
        chk("t6_pre_count", 64'(bus.count), 64'd1);
        rst = 1'b1; tick();
        chk("t6_rst_valid", 64'(bus.result_valid), 64'd0);
        chk("t6_rst_count", 64'(bus.count), 64'd0);
        rst = 1'b0; bus.result_ready = 1'b1;
        bus.alloc_id = 4'd2; tick();
        chk("t6_post_valid", 64'(bus.result_valid), 64'd0);
        chk("t6_post_ready", 64'(bus.alloc_ready), 64'd1);

        repeat (3) tick();
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        chk("n_results", 64'(n_results), 64'd24);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
